// File: rtl/imu_pkg.sv
// Shared types and SPI command words for the IMU yaw-rate read controller.
package imu_pkg;

    typedef enum logic [2:0] {
        PWRUP    = 3'd0,
        CFG1     = 3'd1,
        CFG2     = 3'd2,
        CFG3     = 3'd3,
        WAIT_INT = 3'd4,
        RD_L     = 3'd5,
        RD_H     = 3'd6
    } imu_state_t;

    // Write commands: {1'b0, reg[6:0], data[7:0]}; reads set bit 15 with zero data.
    localparam logic [15:0] CMD_INT_EN   = 16'h0D02;
    localparam logic [15:0] CMD_GYRO_ODR = 16'h1160;
    localparam logic [15:0] CMD_ROUND    = 16'h1440;
    localparam logic [15:0] CMD_RD_YAWL  = 16'hA600;
    localparam logic [15:0] CMD_RD_YAWH  = 16'hA700;

endpackage

// File: rtl/int_sync.sv
// Two-flop synchronizer bringing the IMU data-ready level into the clk domain.
module int_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out
);

    logic meta_q;
    logic sync_q;

    // Metastability filter: first flop may go metastable, second settles it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
        end
    end

    assign sync_out = sync_q;

endmodule

// File: rtl/imu_rd_ctrl.sv
// IMU controller: power-up wait, three configuration writes, then a Z-gyro
// low/high byte read pair on every synchronized data-ready indication.
module imu_rd_ctrl
    import imu_pkg::*;
#(
    parameter logic [15:0] PWRUP_CYC = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        INT,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic        wrt,
    output logic [15:0] cmd,
    output logic        init_done,
    output logic [15:0] yaw_rt,
    output logic        vld
);

    imu_state_t  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        wrt_q, wrt_d;
    logic [15:0] cmd_q, cmd_d;
    logic        init_done_q, init_done_d;
    logic [7:0]  yaw_l_q, yaw_l_d;
    logic [15:0] yaw_rt_q, yaw_rt_d;
    logic        vld_q, vld_d;
    logic        int_ff2;
    logic [7:0]  rd_hi_unused;

    // Only the low byte of each register read carries data.
    assign rd_hi_unused = rd_data[15:8];

    int_sync u_int_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (INT),
        .sync_out (int_ff2)
    );

    // Next-state and next-output decode for the read sequencer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wrt_d       = 1'b0;
        cmd_d       = cmd_q;
        init_done_d = init_done_q;
        yaw_l_d     = yaw_l_q;
        yaw_rt_d    = yaw_rt_q;
        vld_d       = 1'b0;
        case (state_q)
            PWRUP: begin
                if (cnt_q == PWRUP_CYC) begin
                    wrt_d   = 1'b1;
                    cmd_d   = CMD_INT_EN;
                    state_d = CFG1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            CFG1: begin
                if (done) begin
                    wrt_d   = 1'b1;
                    cmd_d   = CMD_GYRO_ODR;
                    state_d = CFG2;
                end else begin
                    state_d = CFG1;
                end
            end
            CFG2: begin
                if (done) begin
                    wrt_d   = 1'b1;
                    cmd_d   = CMD_ROUND;
                    state_d = CFG3;
                end else begin
                    state_d = CFG2;
                end
            end
            CFG3: begin
                if (done) begin
                    init_done_d = 1'b1;
                    state_d     = WAIT_INT;
                end else begin
                    state_d = CFG3;
                end
            end
            WAIT_INT: begin
                // The vld cycle is skipped so a new read never starts sooner
                // than three cycles after the previous high-byte done.
                if (int_ff2 && !vld_q) begin
                    wrt_d   = 1'b1;
                    cmd_d   = CMD_RD_YAWL;
                    state_d = RD_L;
                end else begin
                    state_d = WAIT_INT;
                end
            end
            RD_L: begin
                if (done) begin
                    yaw_l_d = rd_data[7:0];
                    wrt_d   = 1'b1;
                    cmd_d   = CMD_RD_YAWH;
                    state_d = RD_H;
                end else begin
                    state_d = RD_L;
                end
            end
            RD_H: begin
                if (done) begin
                    yaw_rt_d = {rd_data[7:0], yaw_l_q};
                    vld_d    = 1'b1;
                    state_d  = WAIT_INT;
                end else begin
                    state_d = RD_H;
                end
            end
            default: begin
                state_d = PWRUP;
            end
        endcase
    end

    // State and registered outputs; reset abandons any in-flight transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= PWRUP;
            cnt_q       <= 16'd0;
            wrt_q       <= 1'b0;
            cmd_q       <= 16'h0000;
            init_done_q <= 1'b0;
            yaw_l_q     <= 8'h00;
            yaw_rt_q    <= 16'h0000;
            vld_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wrt_q       <= wrt_d;
            cmd_q       <= cmd_d;
            init_done_q <= init_done_d;
            yaw_l_q     <= yaw_l_d;
            yaw_rt_q    <= yaw_rt_d;
            vld_q       <= vld_d;
        end
    end

    assign wrt       = wrt_q;
    assign cmd       = cmd_q;
    assign init_done = init_done_q;
    assign yaw_rt    = yaw_rt_q;
    assign vld       = vld_q;

endmodule
